// File: rtl/instr_loader.sv
// instr_loader: encodes symbolic MIPS instructions into 32-bit words and
// streams them into instruction memory, one word per accepted handshake.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LOAD  | accepting instructions, one write per valid accept
// FLUSH | one cycle to let the last write drain
// DONE  | session complete, waiting for start
module instr_loader #(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_finish,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [4:0]        i_op_sel,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_shamt,
    input  logic [15:0]       i_imm,
    input  logic [25:0]       i_target,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [ADDR_W:0]   o_wr_count,
    output logic              o_bad_op,
    output logic              o_full,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_W  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_wr_count;
    logic                r_bad_op;
    logic                r_full;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_op_valid;
    logic                w_wr_en;
    logic                w_hit_depth;
    logic                w_session_start;
    logic [5:0]          w_opcode;
    logic [5:0]          w_funct;
    logic [4:0]          w_rs_f;
    logic [4:0]          w_rt_f;
    logic [4:0]          w_rd_f;
    logic [4:0]          w_sh_f;
    logic [31:0]         w_word;

    // Encode the presented fields into a MIPS word, applying field forcing.
    always_comb begin
        w_opcode   = 6'b000000;
        w_funct    = 6'b000000;
        w_rs_f     = i_rs;
        w_rt_f     = i_rt;
        w_rd_f     = i_rd;
        w_sh_f     = i_shamt;
        w_word     = 32'h0000_0000;
        w_op_valid = (i_op_sel <= 5'd25);
        case (i_op_sel)
            5'd0:    w_funct = 6'b000000;
            5'd1:    w_funct = 6'b000010;
            5'd2:    w_funct = 6'b000011;
            5'd3:    w_funct = 6'b000100;
            5'd4:    w_funct = 6'b000110;
            5'd5:    w_funct = 6'b001000;
            5'd6:    w_funct = 6'b100000;
            5'd7:    w_funct = 6'b100010;
            5'd8:    w_funct = 6'b100100;
            5'd9:    w_funct = 6'b100101;
            5'd10:   w_funct = 6'b100110;
            5'd11:   w_funct = 6'b100111;
            5'd12:   w_funct = 6'b101010;
            5'd13:   w_funct = 6'b101011;
            5'd14:   w_opcode = 6'b001000;
            5'd15:   w_opcode = 6'b001010;
            5'd16:   w_opcode = 6'b001100;
            5'd17:   w_opcode = 6'b001101;
            5'd18:   w_opcode = 6'b001110;
            5'd19:   w_opcode = 6'b001111;
            5'd20:   w_opcode = 6'b100011;
            5'd21:   w_opcode = 6'b101011;
            5'd22:   w_opcode = 6'b000100;
            5'd23:   w_opcode = 6'b000101;
            5'd24:   w_opcode = 6'b000010;
            5'd25:   w_opcode = 6'b000011;
            default: w_opcode = 6'b000000;
        endcase

        if (i_op_sel <= 5'd13) begin
            // constant shifts carry no rs; jr carries only rs; the rest no shamt
            if (i_op_sel <= 5'd2) begin
                w_rs_f = 5'd0;
            end else if (i_op_sel == 5'd5) begin
                w_rt_f = 5'd0;
                w_rd_f = 5'd0;
                w_sh_f = 5'd0;
            end else begin
                w_sh_f = 5'd0;
            end
            w_word = {6'b000000, w_rs_f, w_rt_f, w_rd_f, w_sh_f, w_funct};
        end else if (i_op_sel <= 5'd23) begin
            if (i_op_sel == 5'd19) begin
                w_rs_f = 5'd0;
            end
            w_word = {w_opcode, w_rs_f, w_rt_f, i_imm};
        end else begin
            w_word = {w_opcode, i_target};
        end
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake; ready depends on registered state only.
    always_comb begin
        w_state_nxt     = r_state;
        w_in_ready      = (r_state == LOAD) && (r_wr_count < DEPTH_W);
        w_accept        = i_in_valid && w_in_ready;
        w_wr_en         = w_accept && w_op_valid;
        w_hit_depth     = w_wr_en && (r_wr_count == LAST_W);
        w_session_start = i_start && ((r_state == IDLE) || (r_state == DONE));
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_hit_depth || i_finish || (r_wr_count >= DEPTH_W)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (i_start) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write stage, pointer, counters and sticky flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr       <= BASE_W;
            r_wr_count  <= '0;
            r_bad_op    <= 1'b0;
            r_full      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_mem_we <= w_wr_en;
            if (w_session_start) begin
                r_ptr      <= BASE_W;
                r_wr_count <= '0;
                r_bad_op   <= 1'b0;
                r_full     <= 1'b0;
            end
            if (w_wr_en) begin
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= w_word;
                r_ptr       <= r_ptr + 1'b1;
                r_wr_count  <= r_wr_count + 1'b1;
            end
            if (w_accept && !w_op_valid) begin
                r_bad_op <= 1'b1;
            end
            if (w_hit_depth) begin
                r_full <= 1'b1;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_wr_count  = r_wr_count;
    assign o_bad_op    = r_bad_op;
    assign o_full      = r_full;
    assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-depth instance for encoding,
// streaming and reset, plus a DEPTH=4 instance for the full boundary.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start4;
    logic        finish;
    logic        in_valid;
    logic [4:0]  op_sel, rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic        in_ready, mem_we, bad_op, full, done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  wr_count;

    logic        in_ready4, mem_we4, bad_op4, full4, done4;
    logic [7:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [8:0]  wr_count4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_loader u_dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_finish(finish),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_op_sel(op_sel),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_imm(imm),
        .i_target(target), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_wr_count(wr_count), .o_bad_op(bad_op),
        .o_full(full), .o_done(done)
    );

    instr_loader #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) u_dut4 (
        .i_clock(clk), .i_reset(rst), .i_start(start4), .i_finish(finish),
        .i_in_valid(in_valid), .o_in_ready(in_ready4), .i_op_sel(op_sel),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_imm(imm),
        .i_target(target), .o_mem_we(mem_we4), .o_mem_addr(mem_addr4),
        .o_mem_wdata(mem_wdata4), .o_wr_count(wr_count4), .o_bad_op(bad_op4),
        .o_full(full4), .o_done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [4:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                              input logic [4:0] f_rd, input logic [4:0] f_sh,
                              input logic [15:0] f_imm, input logic [25:0] f_tgt);
        op_sel = op;
        rs     = f_rs;
        rt     = f_rt;
        rd     = f_rd;
        shamt  = f_sh;
        imm    = f_imm;
        target = f_tgt;
    endtask

    task automatic exp_wr(input string tag, input logic [7:0] addr, input logic [31:0] word);
        check({tag, "_we"},   32'(mem_we),    32'd1);
        check({tag, "_addr"}, 32'(mem_addr),  32'(addr));
        check({tag, "_data"}, mem_wdata,      word);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        tick();
        check("rst_ready", 32'(in_ready),  32'd0);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_data",  mem_wdata,      32'd0);
        check("rst_cnt",   32'(wr_count),  32'd0);
        check("rst_flags", 32'({bad_op, full, done}), 32'd0);
        rst = 1'b0;

        // session 1: encoding and field forcing
        start = 1'b1; tick(); start = 1'b0;
        check("s1_ready", 32'(in_ready), 32'd1);
        check("s1_cnt0",  32'(wr_count), 32'd0);
        set_fields(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        exp_wr("add", 8'd0, 32'h0022_1820);
        check("add_cnt", 32'(wr_count), 32'd1);
        tick();
        check("gap_we",   32'(mem_we),   32'd0);
        check("gap_hold", mem_wdata,     32'h0022_1820);
        set_fields(5'd20, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        in_valid = 1'b1; tick();
        exp_wr("lw", 8'd1, 32'h8FA8_0004);
        set_fields(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000);
        tick();
        exp_wr("j", 8'd2, 32'h0810_0000);
        set_fields(5'd0, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
        tick();
        exp_wr("sll", 8'd3, 32'h0001_1100);
        set_fields(5'd19, 5'd9, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0);
        tick();
        exp_wr("lui", 8'd4, 32'h3C05_1234);
        in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
        check("s1_flush_ready", 32'(in_ready), 32'd0);
        check("s1_flush_done",  32'(done),     32'd0);
        check("s1_flush_we",    32'(mem_we),   32'd0);
        tick();
        check("s1_done", 32'(done),     32'd1);
        check("s1_cnt",  32'(wr_count), 32'd5);
        check("s1_bad",  32'(bad_op),   32'd0);
        check("s1_full", 32'(full),     32'd0);

        // session 2: back-to-back stream with an invalid op in the middle
        start = 1'b1; tick(); start = 1'b0;
        check("s2_cnt0", 32'(wr_count), 32'd0);
        check("s2_done", 32'(done),     32'd0);
        set_fields(5'd7, 5'd4, 5'd5, 5'd6, 5'd3, 16'h0, 26'h0);
        in_valid = 1'b1; tick();
        exp_wr("sub", 8'd0, 32'h0085_3022);
        set_fields(5'd5, 5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        exp_wr("jr", 8'd1, 32'h03E0_0008);
        set_fields(5'd27, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h3FF_FFFF);
        tick();
        check("inv_we",   32'(mem_we),   32'd0);
        check("inv_bad",  32'(bad_op),   32'd1);
        check("inv_cnt",  32'(wr_count), 32'd2);
        check("inv_addr", 32'(mem_addr), 32'd1);
        set_fields(5'd22, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        tick();
        exp_wr("beq", 8'd2, 32'h1022_FFFF);
        set_fields(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF);
        tick();
        exp_wr("jal", 8'd3, 32'h0FFF_FFFF);
        set_fields(5'd17, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'h0);
        finish = 1'b1; tick(); finish = 1'b0; in_valid = 1'b0;
        exp_wr("ori", 8'd4, 32'h3464_00FF);
        check("s2_flush_ready", 32'(in_ready), 32'd0);
        check("s2_cnt", 32'(wr_count), 32'd5);
        check("s2_bad", 32'(bad_op),   32'd1);
        tick();
        check("s2_done",    32'(done),   32'd1);
        check("s2_done_we", 32'(mem_we), 32'd0);

        // DEPTH=4 boundary with in_valid held
        set_fields(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1; start4 = 1'b1; tick(); start4 = 1'b0;
        check("d4_ready0", 32'(in_ready4), 32'd1);
        check("d4_we0",    32'(mem_we4),   32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) finish = 1'b1;
            tick();
            check("d4_we",   32'(mem_we4),    32'd1);
            check("d4_addr", 32'(mem_addr4),  32'(k));
            check("d4_data", mem_wdata4,      32'h0022_1820);
            check("d4_cnt",  32'(wr_count4),  32'(k + 1));
        end
        check("d4_ready_low", 32'(in_ready4), 32'd0);
        check("d4_full",      32'(full4),     32'd1);
        check("d4_done_n1",   32'(done4),     32'd0);
        tick();
        check("d4_done_n2", 32'(done4),     32'd1);
        check("d4_we_off",  32'(mem_we4),   32'd0);
        check("d4_cnt_end", 32'(wr_count4), 32'd4);
        check("d4_full_h",  32'(full4),     32'd1);
        in_valid = 1'b0; finish = 1'b0;

        // reset mid-session
        start = 1'b1; tick(); start = 1'b0;
        set_fields(5'd19, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0);
        in_valid = 1'b1; tick();
        set_fields(5'd0, 5'd0, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
        tick();
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        check("mr_we",    32'(mem_we),   32'd0);
        check("mr_addr",  32'(mem_addr), 32'd0);
        check("mr_data",  mem_wdata,     32'd0);
        check("mr_cnt",   32'(wr_count), 32'd0);
        check("mr_ready", 32'(in_ready), 32'd0);
        check("mr_flags", 32'({bad_op, full, done}), 32'd0);
        check("mr_d4",    32'({full4, done4}),       32'd0);
        tick();
        check("mr_idle_we", 32'(mem_we), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        set_fields(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        exp_wr("fresh", 8'd0, 32'h0022_1820);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
